hazard_ctrl_unit: RTL and testbench

//  Control-side counterpart of the id_ex/if_id/ex_mem pipeline registers: generates their stall,

---
 rtl/hazard_ctrl_unit.sv | 171 +++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: stall/flush/forwarding control for the 5-stage pipe,
// plus a busy FSM with watchdog for multi-cycle EX ops.
//
// Ports
//   clk, rst              rising-edge clock, async active-high reset
//   rs1_d, rs2_d          sources of the instruction in D
//   rs1_e, rs2_e          sources of the instruction in E
//   rd_e, rd_m, rd_w      destinations in E / M / W
//   reg_write_m/_w        M / W instruction writes its rd
//   load_e                E instruction is a load
//   pc_src_e              branch/jump taken in E
//   mc_start_e, mc_done   multi-cycle op start in E / result valid
//   stall_f/_d/_e         hold PC, IF-ID, ID-EX
//   flush_d/_e/_m         clear IF-ID, ID-EX, EX-MEM
//   fwd_a_e, fwd_b_e      00 regfile, 01 W result, 10 M ALU result
//   mc_timeout_err        sticky watchdog abort flag
//
// Optional: define HAZARD_PERF_CNT_EN to add saturating stall_cnt and
// flush_cnt outputs (cycles with stall_f / flush_e asserted).
module hazard_ctrl_unit #(
  parameter int MC_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       load_e,
  input  logic       pc_src_e,
  input  logic       mc_start_e,
  input  logic       mc_done,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_m,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       mc_timeout_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int CW = $clog2(MC_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MC_TIMEOUT - 1);

  typedef enum logic {
    RUN,
    MC_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic lw_stall;
  logic busy;
  logic abort;
  logic to;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs
  );
    if (reg_write_m && rd_m != 5'd0 && rd_m == rs)
      return 2'b10;
    else if (reg_write_w && rd_w != 5'd0 && rd_w == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign fwd_a_e = fwd_sel(rs1_e);
  assign fwd_b_e = fwd_sel(rs2_e);

  assign lw_stall = load_e && rd_e != 5'd0 &&
                    (rd_e == rs1_d || rd_e == rs2_d);

  assign to = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    busy    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      RUN: begin
        // Same-cycle done means a single-cycle op; a taken branch
        // squashes the op, so neither enters the wait state.
        if (mc_start_e && !mc_done && !pc_src_e) begin
          busy    = 1'b1;
          state_d = MC_WAIT;
          cnt_d   = '0;
        end
      end
      MC_WAIT: begin
        if (mc_done) begin
          state_d = RUN;
        end else if (to) begin
          abort   = 1'b1;
          state_d = RUN;
          err_d   = 1'b1;
        end else begin
          busy  = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign stall_f = lw_stall | busy;
  assign stall_d = lw_stall | busy;
  assign stall_e = busy;
  assign flush_m = busy;
  assign flush_d = pc_src_e;
  // E is held while busy; a watchdog abort discards the stuck op.
  assign flush_e = ((lw_stall | pc_src_e) & ~busy) | abort;

  assign mc_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush_e && flush_cnt_q != 32'hFFFF_FFFF)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: scoreboard bench for hazard_ctrl_unit
// with directed scenarios and randomized traffic vs a reference model.
module tb_hazard_ctrl_unit;

  localparam int TO = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e;
    logic [4:0] rd_e, rd_m, rd_w;
    logic       wm, ww, ld, pc, mcs, mcd;
  } stim_t;

  typedef struct packed {
    logic [10:0] o;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0;
  logic [4:0] rd_e = '0, rd_m = '0, rd_w = '0;
  logic reg_write_m = 0, reg_write_w = 0, load_e = 0;
  logic pc_src_e = 0, mc_start_e = 0, mc_done = 0;
  logic stall_f, stall_d, stall_e;
  logic flush_d, flush_e, flush_m;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic mc_timeout_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl_unit #(.MC_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .load_e(load_e), .pc_src_e(pc_src_e),
    .mc_start_e(mc_start_e), .mc_done(mc_done),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .mc_timeout_err(mc_timeout_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q[$];
  stim_t s;

  // Reference model: is a multi-cycle op outstanding, how many
  // wait cycles it has used, sticky error, activity counters.
  bit m_wait = 0;
  int m_used = 0;
  bit m_err = 0;
  longint m_sc = 0;
  longint m_fc = 0;

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (s.wm && s.rd_m != 0 && s.rd_m == rs) return 2'b10;
    if (s.ww && s.rd_w != 0 && s.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step();
    bit lw, busy, abort, starts, sf, fe;
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst;
    rs1_d = s.rs1_d; rs2_d = s.rs2_d;
    rs1_e = s.rs1_e; rs2_e = s.rs2_e;
    rd_e = s.rd_e; rd_m = s.rd_m; rd_w = s.rd_w;
    reg_write_m = s.wm; reg_write_w = s.ww;
    load_e = s.ld; pc_src_e = s.pc;
    mc_start_e = s.mcs; mc_done = s.mcd;
    if (s.rst) begin
      m_wait = 0; m_used = 0; m_err = 0;
      m_sc = 0; m_fc = 0;
    end
    lw = s.ld && s.rd_e != 0 &&
         (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d);
    starts = !m_wait && s.mcs && !s.mcd && !s.pc;
    abort = m_wait && !s.mcd && (m_used == TO - 1);
    busy = starts || (m_wait && !s.mcd && !abort);
    sf = lw || busy;
    fe = ((lw || s.pc) && !busy) || abort;
    e.o = {fwd_ref(s.rs1_e), fwd_ref(s.rs2_e),
           sf, sf, busy, s.pc, fe, busy, m_err};
    e.sc = 32'(m_sc);
    e.fc = 32'(m_fc);
    q.push_back(e);
    if (!s.rst) begin
      if (sf && m_sc < 64'hFFFF_FFFF) m_sc++;
      if (fe && m_fc < 64'hFFFF_FFFF) m_fc++;
      if (starts) begin
        m_wait = 1; m_used = 0;
      end else if (m_wait) begin
        if (s.mcd || abort) m_wait = 0;
        else m_used++;
        if (abort) m_err = 1;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic [10:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e,
               flush_d, flush_e, flush_m, mc_timeout_err};
        checks++;
        if (act !== e.o) begin
          errors++;
          $display("FAIL cyc%0d outputs {fa,fb,sf,sd,se,fd,fe,fm,err}: got %b exp %b",
                   cyc, act, e.o);
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
          errors++;
          $display("FAIL cyc%0d perf_cnt: got %0d/%0d exp %0d/%0d",
                   cyc, stall_cnt, flush_cnt, e.sc, e.fc);
        end
`endif
        cyc++;
      end
    end
  end

  initial begin : stimulus
    s = '0;
    s.rst = 1;
    repeat (2) step();
    s.rst = 0;
    step();
    // forwarding priority: M beats W, r0 never forwarded
    s.rd_m = 5; s.wm = 1; s.rd_w = 5; s.ww = 1; s.rs1_e = 5;
    step();
    s.rd_m = 0;
    step();
    s.rs2_e = 5; s.rs1_e = 3; s.wm = 0; s.rd_m = 5;
    step();
    s = '0;
    // load-use hazard and the rd=0 exemption
    s.ld = 1; s.rd_e = 7; s.rs2_d = 7;
    step();
    s.rd_e = 0; s.rs2_d = 0;
    step();
    s.rd_e = 9; s.rs1_d = 9;
    step();
    // branch together with load-use
    s.pc = 1;
    step();
    s.mcs = 1;
    step();
    s = '0;
    step();
    // multi-cycle op, done arrives on the last wait cycle
    s.mcs = 1;
    repeat (4) step();
    s.mcd = 1;
    step();
    s = '0;
    repeat (2) step();
    // single-cycle op
    s.mcs = 1; s.mcd = 1;
    step();
    s = '0;
    // watchdog abort
    s.mcs = 1;
    step();
    s.mcs = 0;
    repeat (4) step();
    repeat (3) step();
    // async reset during the wait state
    s.mcs = 1;
    step();
    s.mcs = 0;
    step();
    s.rst = 1;
    step();
    step();
    s.rst = 0;
    repeat (2) step();
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      s.rst = ($urandom_range(0, 199) == 0);
      s.rs1_d = 5'($urandom_range(0, 7));
      s.rs2_d = 5'($urandom_range(0, 7));
      s.rs1_e = 5'($urandom_range(0, 7));
      s.rs2_e = 5'($urandom_range(0, 7));
      s.rd_e = 5'($urandom_range(0, 7));
      s.rd_m = 5'($urandom_range(0, 7));
      s.rd_w = 5'($urandom_range(0, 7));
      s.wm = 1'($urandom_range(0, 1));
      s.ww = 1'($urandom_range(0, 1));
      s.ld = ($urandom_range(0, 3) == 0);
      s.pc = ($urandom_range(0, 5) == 0);
      s.mcs = ($urandom_range(0, 3) == 0);
      s.mcd = ($urandom_range(0, 5) == 0);
      step();
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
